// File: rtl/laser_safety_pkg.sv
// Shared constants for the laser safety sequencer.
//   - FSM state encodings (exported on ctrl_state)
//   - configuration staging register addresses
//   - bit positions inside fault_code ({rate, upper, lower})
//   - saturating increment used by the fault counter
package laser_safety_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_APPLY   = 3'd1;
    localparam logic [STATE_W-1:0] ST_SETTLE  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ARMED   = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAULT   = 3'd4;
    localparam logic [STATE_W-1:0] ST_CLEAR   = 3'd5;
    localparam logic [STATE_W-1:0] ST_LOCKOUT = 3'd6;
    localparam logic [STATE_W-1:0] ST_LATCHED = 3'd7;

    localparam logic [1:0] CFG_PW_LOWER   = 2'd0;
    localparam logic [1:0] CFG_PW_UPPER   = 2'd1;
    localparam logic [1:0] CFG_RATE_LOWER = 2'd2;
    localparam logic [1:0] CFG_RESERVED   = 2'd3;

    localparam int FC_LOWER = 0;
    localparam int FC_UPPER = 1;
    localparam int FC_RATE  = 2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/safety_timer.sv
// Loadable down-counter shared by the timed states of laser_safety_ctrl.
// Ports:
//   clk, rst   system clock, async active-high reset
//   load       load load_val into the counter (a value of 0 is loaded as 1)
//   load_val   cycle count for the state being entered
//   done       high while the counter sits at terminal count 1, i.e. during
//              the last cycle of the timed interval
module safety_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = (load_val == '0) ? CNT_W'(1) : load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/laser_safety_ctrl.sv
// Sequencer/configurator for the pulse-width/rate checker. Stages and
// validates limit registers, applies them atomically, arms the laser, disarms
// on any checker fail flag and runs the ack / timed clear / lockout recovery.
// Ports:
//   clk, rst                     system clock, async active-high reset
//   cfg_wr/cfg_addr/cfg_wdata    staging register write (addr 3 reserved)
//   arm_req, disarm_req          1-cycle host requests
//   ack_fault                    host acknowledge of a fault
//   fail_lower/upper/rate        checker fail flags (checker clock domain)
//   laser_ready                  laser enable (registered)
//   clear_fail                   checker fail clear (registered)
//   pw_lower_lim/pw_upper_lim/rate_lower_lim   active limits
//   fault_code                   {rate,upper,lower} captured at fault entry
//   fault_count                  saturating fault counter
//   cfg_err                      1-cycle pulse on rejected write or arm
//   ctrl_state                   current state encoding
//
// state   | meaning
// IDLE    | laser off, staging registers writable, waiting for arm_req
// APPLY   | one cycle: staging copied to the active limits
// SETTLE  | waiting SETTLE_CYCLES for the checker to see new limits
// ARMED   | laser_ready high
// FAULT   | fail seen, waiting for ack_fault
// CLEAR   | clear_fail held for CLEAR_HOLD cycles
// LOCKOUT | LOCKOUT_CYCLES hold-off before re-arm is possible
// LATCHED | too many faults, only rst leaves
module laser_safety_ctrl
    import laser_safety_pkg::*;
#(
    parameter int LIMIT_W        = 32,
    parameter int SETTLE_CYCLES  = 32,
    parameter int CLEAR_HOLD     = 16,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int MAX_FAULTS     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_addr,
    input  logic [LIMIT_W-1:0] cfg_wdata,
    input  logic               arm_req,
    input  logic               disarm_req,
    input  logic               ack_fault,
    input  logic               fail_lower,
    input  logic               fail_upper,
    input  logic               fail_rate,
    output logic               laser_ready,
    output logic               clear_fail,
    output logic [LIMIT_W-1:0] pw_lower_lim,
    output logic [LIMIT_W-1:0] pw_upper_lim,
    output logic [LIMIT_W-1:0] rate_lower_lim,
    output logic [2:0]         fault_code,
    output logic [7:0]         fault_count,
    output logic               cfg_err,
    output logic [2:0]         ctrl_state
);

    localparam int         TMR_W        = 16;
    localparam logic [7:0] MAX_FAULTS_C = 8'(MAX_FAULTS);

    logic [2:0] fail_raw;
    logic [2:0] fail_meta_q;
    logic [2:0] fail_sync_q;
    logic       fail_any;

    logic [STATE_W-1:0] state_q, state_d;
    logic [LIMIT_W-1:0] stg_pw_lower_q, stg_pw_lower_d;
    logic [LIMIT_W-1:0] stg_pw_upper_q, stg_pw_upper_d;
    logic [LIMIT_W-1:0] stg_rate_lower_q, stg_rate_lower_d;
    logic [LIMIT_W-1:0] act_pw_lower_q, act_pw_lower_d;
    logic [LIMIT_W-1:0] act_pw_upper_q, act_pw_upper_d;
    logic [LIMIT_W-1:0] act_rate_lower_q, act_rate_lower_d;
    logic [2:0]         fault_code_q, fault_code_d;
    logic [7:0]         fault_count_q, fault_count_d;
    logic               cfg_err_q, cfg_err_d;
    logic               laser_ready_q, laser_ready_d;
    logic               clear_fail_q, clear_fail_d;

    logic               cfg_valid;
    logic               fault_hit;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_done;

    assign fail_raw[FC_LOWER] = fail_lower;
    assign fail_raw[FC_UPPER] = fail_upper;
    assign fail_raw[FC_RATE]  = fail_rate;

    // Two-flop synchronizer per flag; the checker runs on a slower clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_meta_q <= '0;
            fail_sync_q <= '0;
        end else begin
            fail_meta_q <= fail_raw;
            fail_sync_q <= fail_meta_q;
        end
    end

    assign fail_any = |fail_sync_q;

    always_comb begin
        state_d          = state_q;
        stg_pw_lower_d   = stg_pw_lower_q;
        stg_pw_upper_d   = stg_pw_upper_q;
        stg_rate_lower_d = stg_rate_lower_q;
        act_pw_lower_d   = act_pw_lower_q;
        act_pw_upper_d   = act_pw_upper_q;
        act_rate_lower_d = act_rate_lower_q;
        fault_code_d     = fault_code_q;
        fault_count_d    = fault_count_q;
        cfg_err_d        = 1'b0;
        fault_hit        = 1'b0;

        if (cfg_wr) begin
            if (state_q == ST_IDLE) begin
                case (cfg_addr)
                    CFG_PW_LOWER:   stg_pw_lower_d   = cfg_wdata;
                    CFG_PW_UPPER:   stg_pw_upper_d   = cfg_wdata;
                    CFG_RATE_LOWER: stg_rate_lower_d = cfg_wdata;
                    default:        ;
                endcase
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        // Validated against the post-write values so a write and an arm in
        // the same cycle behave as write-then-arm.
        cfg_valid = (stg_pw_lower_d < stg_pw_upper_d) &&
                    (stg_rate_lower_d > stg_pw_upper_d);

        case (state_q)
            ST_IDLE: begin
                if (arm_req) begin
                    if (cfg_valid) begin
                        state_d = ST_APPLY;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_APPLY: begin
                act_pw_lower_d   = stg_pw_lower_q;
                act_pw_upper_d   = stg_pw_upper_q;
                act_rate_lower_d = stg_rate_lower_q;
                state_d          = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (fail_any) begin
                    fault_hit = 1'b1;
                end else if (disarm_req) begin
                    state_d = ST_IDLE;
                end else if (tmr_done) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (fail_any) begin
                    fault_hit = 1'b1;
                end else if (disarm_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (ack_fault) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (tmr_done) begin
                    state_d = ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    if (fail_any) begin
                        fault_hit = 1'b1;
                    end else begin
                        state_d      = ST_IDLE;
                        fault_code_d = '0;
                    end
                end
            end
            ST_LATCHED: begin
                state_d = ST_LATCHED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fault_hit) begin
            fault_count_d = sat_inc8(fault_count_q);
            fault_code_d  = fail_sync_q;
            state_d       = (fault_count_d >= MAX_FAULTS_C) ? ST_LATCHED : ST_FAULT;
        end

        // Qualified with state_d so a fault or disarm drops the enable on the
        // same edge that leaves ARMED.
        laser_ready_d = (state_q == ST_ARMED) && (state_d == ST_ARMED);
        clear_fail_d  = (state_d == ST_CLEAR);
    end

    always_comb begin
        tmr_load = (state_d != state_q) &&
                   ((state_d == ST_SETTLE) || (state_d == ST_CLEAR) ||
                    (state_d == ST_LOCKOUT));
        case (state_d)
            ST_SETTLE: tmr_val = TMR_W'(SETTLE_CYCLES);
            ST_CLEAR:  tmr_val = TMR_W'(CLEAR_HOLD);
            default:   tmr_val = TMR_W'(LOCKOUT_CYCLES);
        endcase
    end

    safety_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            stg_pw_lower_q   <= '0;
            stg_pw_upper_q   <= '0;
            stg_rate_lower_q <= '0;
            act_pw_lower_q   <= '0;
            act_pw_upper_q   <= '0;
            act_rate_lower_q <= '0;
            fault_code_q     <= '0;
            fault_count_q    <= '0;
            cfg_err_q        <= 1'b0;
            laser_ready_q    <= 1'b0;
            clear_fail_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            stg_pw_lower_q   <= stg_pw_lower_d;
            stg_pw_upper_q   <= stg_pw_upper_d;
            stg_rate_lower_q <= stg_rate_lower_d;
            act_pw_lower_q   <= act_pw_lower_d;
            act_pw_upper_q   <= act_pw_upper_d;
            act_rate_lower_q <= act_rate_lower_d;
            fault_code_q     <= fault_code_d;
            fault_count_q    <= fault_count_d;
            cfg_err_q        <= cfg_err_d;
            laser_ready_q    <= laser_ready_d;
            clear_fail_q     <= clear_fail_d;
        end
    end

    assign laser_ready    = laser_ready_q;
    assign clear_fail     = clear_fail_q;
    assign pw_lower_lim   = act_pw_lower_q;
    assign pw_upper_lim   = act_pw_upper_q;
    assign rate_lower_lim = act_rate_lower_q;
    assign fault_code     = fault_code_q;
    assign fault_count    = fault_count_q;
    assign cfg_err        = cfg_err_q;
    assign ctrl_state     = state_q;

endmodule

// File: tb/tb_laser_safety_ctrl.sv
// Self-checking bench for laser_safety_ctrl with randomized limit values and
// fault flags, checked against a cycle-count/arithmetic reference model.
module tb_laser_safety_ctrl;
    import laser_safety_pkg::*;

    localparam int LW     = 32;
    localparam int SETTLE = 32;
    localparam int CLR    = 16;
    localparam int LOCK   = 1000;
    localparam int MAXF   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_wr, arm_req, disarm_req, ack_fault;
    logic [1:0]    cfg_addr;
    logic [LW-1:0] cfg_wdata;
    logic          fail_lower, fail_upper, fail_rate;
    logic          laser_ready, clear_fail, cfg_err;
    logic [LW-1:0] pw_lower_lim, pw_upper_lim, rate_lower_lim;
    logic [2:0]    fault_code, ctrl_state;
    logic [7:0]    fault_count;

    int checks = 0;
    int errors = 0;

    // reference model
    int            m_count;
    logic [LW-1:0] m_stg_l, m_stg_u, m_stg_r;
    logic [LW-1:0] m_act_l, m_act_u, m_act_r;

    laser_safety_ctrl #(
        .LIMIT_W(LW), .SETTLE_CYCLES(SETTLE), .CLEAR_HOLD(CLR),
        .LOCKOUT_CYCLES(LOCK), .MAX_FAULTS(MAXF)
    ) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .arm_req(arm_req), .disarm_req(disarm_req), .ack_fault(ack_fault),
        .fail_lower(fail_lower), .fail_upper(fail_upper), .fail_rate(fail_rate),
        .laser_ready(laser_ready), .clear_fail(clear_fail),
        .pw_lower_lim(pw_lower_lim), .pw_upper_lim(pw_upper_lim), .rate_lower_lim(rate_lower_lim),
        .fault_code(fault_code), .fault_count(fault_count), .cfg_err(cfg_err),
        .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit cfg_ok(input logic [LW-1:0] l, input logic [LW-1:0] u, input logic [LW-1:0] r);
        return (l < u) && (r > u);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_count = 0;
        m_stg_l = '0; m_stg_u = '0; m_stg_r = '0;
        m_act_l = '0; m_act_u = '0; m_act_r = '0;
    endtask

    task automatic write_cfg(input logic [1:0] addr, input logic [LW-1:0] data);
        cfg_wr = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_wr = 1'b0;
        case (addr)
            CFG_PW_LOWER:   m_stg_l = data;
            CFG_PW_UPPER:   m_stg_u = data;
            CFG_RATE_LOWER: m_stg_r = data;
            default:        ;
        endcase
    endtask

    // Cycles from the arm edge to laser_ready, -1 on timeout.
    task automatic arm_wait(output int n);
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        n = 0;
        while (laser_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (laser_ready !== 1'b1) n = -1;
        m_act_l = m_stg_l; m_act_u = m_stg_u; m_act_r = m_stg_r;
    endtask

    // Cycles until laser_ready drops after the caller raised a fail flag.
    task automatic drop_wait(output int n);
        n = 0;
        while (laser_ready === 1'b1 && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic recover(output int clr_n, output int lock_n, output logic [2:0] code);
        ack_fault = 1'b1;
        tick();
        ack_fault = 1'b0;
        code = fault_code;
        clr_n = 0;
        while (clear_fail === 1'b1 && clr_n < 100) begin
            clr_n++;
            tick();
        end
        lock_n = 0;
        while (ctrl_state === ST_LOCKOUT && lock_n < 2000) begin
            lock_n++;
            tick();
        end
    endtask

    task automatic test_reset();
        checks++; if (laser_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", laser_ready); end
        checks++; if (clear_fail !== 1'b0) begin errors++; $display("FAIL reset_clear got %0b want 0", clear_fail); end
        checks++; if ({pw_lower_lim, pw_upper_lim, rate_lower_lim} !== '0) begin errors++; $display("FAIL reset_limits got %0h/%0h/%0h want 0", pw_lower_lim, pw_upper_lim, rate_lower_lim); end
        checks++; if (fault_code !== 3'b000) begin errors++; $display("FAIL reset_code got %0b want 0", fault_code); end
        checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fault_count); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %0b want 0", cfg_err); end
        checks++; if (ctrl_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", ctrl_state, ST_IDLE); end
    endtask

    task automatic test_arm_timing();
        logic [LW-1:0] l, u, r;
        int n;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                l = 100; u = 200; r = 1000;
            end else begin
                l = $urandom_range(0, 1000000);
                u = l + 1 + $urandom_range(0, 5000);
                r = u + 1 + $urandom_range(0, 1000000);
            end
            write_cfg(CFG_PW_LOWER, l);
            write_cfg(CFG_PW_UPPER, u);
            write_cfg(CFG_RATE_LOWER, r);
            checks++; if (pw_lower_lim !== m_act_l || pw_upper_lim !== m_act_u) begin errors++; $display("FAIL stage_no_apply got %0d/%0d want %0d/%0d", pw_lower_lim, pw_upper_lim, m_act_l, m_act_u); end
            arm_req = 1'b1;
            tick();
            arm_req = 1'b0;
            checks++; if (ctrl_state !== ST_APPLY) begin errors++; $display("FAIL arm_apply_state got %0d want %0d", ctrl_state, ST_APPLY); end
            checks++; if (cfg_err !== !cfg_ok(l, u, r)) begin errors++; $display("FAIL arm_valid_err got %0b want %0b", cfg_err, !cfg_ok(l, u, r)); end
            checks++; if (pw_lower_lim !== m_act_l || rate_lower_lim !== m_act_r) begin errors++; $display("FAIL limits_before_apply got %0d/%0d want %0d/%0d", pw_lower_lim, rate_lower_lim, m_act_l, m_act_r); end
            tick();
            m_act_l = m_stg_l; m_act_u = m_stg_u; m_act_r = m_stg_r;
            checks++; if (pw_lower_lim !== m_act_l || pw_upper_lim !== m_act_u || rate_lower_lim !== m_act_r) begin errors++; $display("FAIL limits_after_apply got %0d/%0d/%0d want %0d/%0d/%0d", pw_lower_lim, pw_upper_lim, rate_lower_lim, m_act_l, m_act_u, m_act_r); end
            n = 1;
            while (laser_ready !== 1'b1 && n < 200) begin
                tick();
                n++;
            end
            checks++; if (n !== SETTLE + 2) begin errors++; $display("FAIL arm_latency got %0d want %0d", n, SETTLE + 2); end
            checks++; if (ctrl_state !== ST_ARMED) begin errors++; $display("FAIL armed_state got %0d want %0d", ctrl_state, ST_ARMED); end
            cfg_wr = 1'b1; cfg_addr = 2'($urandom_range(0, 2)); cfg_wdata = $urandom;
            tick();
            cfg_wr = 1'b0;
            checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL armed_write_err got %0b want 1", cfg_err); end
            tick();
            checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse got %0b want 0", cfg_err); end
            arm_req = 1'b1;
            tick();
            arm_req = 1'b0;
            checks++; if (ctrl_state !== ST_ARMED || laser_ready !== 1'b1) begin errors++; $display("FAIL armed_arm_ignored got state %0d ready %0b want %0d 1", ctrl_state, laser_ready, ST_ARMED); end
            disarm_req = 1'b1;
            tick();
            disarm_req = 1'b0;
            checks++; if (ctrl_state !== ST_IDLE || laser_ready !== 1'b0) begin errors++; $display("FAIL disarm got state %0d ready %0b want %0d 0", ctrl_state, laser_ready, ST_IDLE); end
        end
        // Re-arm without writes: the rejected write while armed must not have touched staging.
        arm_wait(n);
        checks++; if (pw_lower_lim !== m_act_l || pw_upper_lim !== m_act_u || rate_lower_lim !== m_act_r) begin errors++; $display("FAIL staging_kept got %0d/%0d/%0d want %0d/%0d/%0d", pw_lower_lim, pw_upper_lim, rate_lower_lim, m_act_l, m_act_u, m_act_r); end
        disarm_req = 1'b1;
        tick();
        disarm_req = 1'b0;
    endtask

    task automatic test_invalid();
        logic [LW-1:0] l, u, r;
        int n;
        for (int it = 0; it < 4; it++) begin
            case (it)
                0: begin l = 100; u = 50; r = 1000; end
                1: begin l = $urandom_range(0, 100000); u = l; r = l + 1 + $urandom_range(0, 1000); end
                2: begin l = $urandom_range(0, 100000); u = l + 1 + $urandom_range(0, 1000); r = u; end
                default: begin u = $urandom_range(0, 1000); l = u + $urandom_range(0, 1000); r = $urandom_range(0, 100000); end
            endcase
            write_cfg(CFG_PW_LOWER, l);
            write_cfg(CFG_PW_UPPER, u);
            write_cfg(CFG_RATE_LOWER, r);
            arm_req = 1'b1;
            tick();
            arm_req = 1'b0;
            checks++; if (cfg_err !== !cfg_ok(l, u, r)) begin errors++; $display("FAIL invalid_err case %0d got %0b want %0b", it, cfg_err, !cfg_ok(l, u, r)); end
            checks++; if (ctrl_state !== ST_IDLE || laser_ready !== 1'b0) begin errors++; $display("FAIL invalid_stay case %0d got state %0d ready %0b want %0d 0", it, ctrl_state, laser_ready, ST_IDLE); end
            tick();
            checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL invalid_pulse case %0d got %0b want 0", it, cfg_err); end
            checks++; if (pw_lower_lim !== m_act_l || pw_upper_lim !== m_act_u || rate_lower_lim !== m_act_r) begin errors++; $display("FAIL invalid_limits case %0d got %0d/%0d/%0d want %0d/%0d/%0d", it, pw_lower_lim, pw_upper_lim, rate_lower_lim, m_act_l, m_act_u, m_act_r); end
        end
        write_cfg(CFG_PW_LOWER, 100);
        write_cfg(CFG_PW_UPPER, 50);
        write_cfg(CFG_RATE_LOWER, 1000);
        write_cfg(CFG_RESERVED, 32'hFFFF_FFFF);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reserved_write_err got %0b want 0", cfg_err); end
        // Write and arm in the same cycle: validation sees the new upper limit.
        cfg_wr = 1'b1; cfg_addr = CFG_PW_UPPER; cfg_wdata = 200; arm_req = 1'b1;
        tick();
        cfg_wr = 1'b0; arm_req = 1'b0;
        m_stg_u = 200;
        checks++; if (ctrl_state !== ST_APPLY || cfg_err !== 1'b0) begin errors++; $display("FAIL write_arm_same got state %0d err %0b want %0d 0", ctrl_state, cfg_err, ST_APPLY); end
        tick();
        m_act_l = m_stg_l; m_act_u = m_stg_u; m_act_r = m_stg_r;
        checks++; if (pw_lower_lim !== 100 || pw_upper_lim !== 200 || rate_lower_lim !== 1000) begin errors++; $display("FAIL write_arm_limits got %0d/%0d/%0d want 100/200/1000", pw_lower_lim, pw_upper_lim, rate_lower_lim); end
        n = 0;
        while (laser_ready !== 1'b1 && n < 200) begin tick(); n++; end
        checks++; if (laser_ready !== 1'b1) begin errors++; $display("FAIL write_arm_ready got %0b want 1", laser_ready); end
        disarm_req = 1'b1;
        tick();
        disarm_req = 1'b0;
    endtask

    task automatic test_fault_upper();
        int n, clr_n, lock_n;
        logic [2:0] code;
        arm_wait(n);
        checks++; if (n !== SETTLE + 2) begin errors++; $display("FAIL fu_arm got %0d want %0d", n, SETTLE + 2); end
        fail_upper = 1'b1;
        drop_wait(n);
        m_count++;
        checks++; if (n < 1 || n > 3) begin errors++; $display("FAIL fu_drop_latency got %0d want 1..3", n); end
        checks++; if (fault_code !== 3'b010) begin errors++; $display("FAIL fu_code got %0b want 010", fault_code); end
        checks++; if (fault_count !== 8'(m_count)) begin errors++; $display("FAIL fu_count got %0d want %0d", fault_count, m_count); end
        checks++; if (ctrl_state !== ST_FAULT) begin errors++; $display("FAIL fu_state got %0d want %0d", ctrl_state, ST_FAULT); end
        fail_upper = 1'b0;
        repeat ($urandom_range(1, 8)) tick();
        arm_req = 1'b1; tick(); arm_req = 1'b0;
        disarm_req = 1'b1; tick(); disarm_req = 1'b0;
        checks++; if (ctrl_state !== ST_FAULT || laser_ready !== 1'b0) begin errors++; $display("FAIL fu_requests_ignored got state %0d ready %0b want %0d 0", ctrl_state, laser_ready, ST_FAULT); end
        recover(clr_n, lock_n, code);
        checks++; if (code !== 3'b010) begin errors++; $display("FAIL fu_code_in_clear got %0b want 010", code); end
        checks++; if (clr_n !== CLR) begin errors++; $display("FAIL fu_clear_len got %0d want %0d", clr_n, CLR); end
        checks++; if (lock_n !== LOCK) begin errors++; $display("FAIL fu_lockout_len got %0d want %0d", lock_n, LOCK); end
        checks++; if (ctrl_state !== ST_IDLE || fault_code !== 3'b000) begin errors++; $display("FAIL fu_back_idle got state %0d code %0b want %0d 000", ctrl_state, fault_code, ST_IDLE); end
        checks++; if (fault_count !== 8'(m_count)) begin errors++; $display("FAIL fu_count_kept got %0d want %0d", fault_count, m_count); end
    endtask

    task automatic test_fault_disarm_same();
        int n, clr_n, lock_n;
        logic [2:0] code;
        arm_wait(n);
        fail_rate = 1'b1;
        tick();
        tick();
        disarm_req = 1'b1;
        tick();
        disarm_req = 1'b0;
        m_count++;
        checks++; if (ctrl_state !== ST_FAULT) begin errors++; $display("FAIL fd_state got %0d want %0d", ctrl_state, ST_FAULT); end
        checks++; if (fault_code !== 3'b100) begin errors++; $display("FAIL fd_code got %0b want 100", fault_code); end
        checks++; if (fault_count !== 8'(m_count)) begin errors++; $display("FAIL fd_count got %0d want %0d", fault_count, m_count); end
        fail_rate = 1'b0;
        repeat (4) tick();
        recover(clr_n, lock_n, code);
        checks++; if (lock_n !== LOCK || ctrl_state !== ST_IDLE) begin errors++; $display("FAIL fd_recover got lock %0d state %0d want %0d %0d", lock_n, lock_n, LOCK, ST_IDLE); end
    endtask

    task automatic test_fault_random();
        int n, clr_n, lock_n;
        logic [2:0] mask, code;
        mask = 3'($urandom_range(1, 7));
        arm_wait(n);
        repeat ($urandom_range(0, 15)) tick();
        {fail_rate, fail_upper, fail_lower} = mask;
        drop_wait(n);
        m_count++;
        checks++; if (n < 1 || n > 3) begin errors++; $display("FAIL fr_drop_latency got %0d want 1..3", n); end
        checks++; if (fault_code !== mask) begin errors++; $display("FAIL fr_code got %0b want %0b", fault_code, mask); end
        checks++; if (fault_count !== 8'(m_count)) begin errors++; $display("FAIL fr_count got %0d want %0d", fault_count, m_count); end
        {fail_rate, fail_upper, fail_lower} = 3'b000;
        repeat (4) tick();
        recover(clr_n, lock_n, code);
        checks++; if (clr_n !== CLR || lock_n !== LOCK) begin errors++; $display("FAIL fr_recover got clear %0d lock %0d want %0d %0d", clr_n, lock_n, CLR, LOCK); end
    endtask

    task automatic test_latched();
        int n, clr_n, lock_n;
        logic [2:0] code;
        do_reset();
        write_cfg(CFG_PW_LOWER, 100);
        write_cfg(CFG_PW_UPPER, 200);
        write_cfg(CFG_RATE_LOWER, 1000);
        // fault 1, flag kept high through lockout -> fault 2 at lockout end
        arm_wait(n);
        fail_lower = 1'b1;
        drop_wait(n);
        m_count++;
        recover(clr_n, lock_n, code);
        m_count++;
        checks++; if (lock_n !== LOCK) begin errors++; $display("FAIL la_refault_lock got %0d want %0d", lock_n, LOCK); end
        checks++; if (ctrl_state !== ST_FAULT || fault_code !== 3'b001) begin errors++; $display("FAIL la_refault got state %0d code %0b want %0d 001", ctrl_state, fault_code, ST_FAULT); end
        checks++; if (fault_count !== 8'(m_count)) begin errors++; $display("FAIL la_refault_count got %0d want %0d", fault_count, m_count); end
        fail_lower = 1'b0;
        repeat (4) tick();
        recover(clr_n, lock_n, code);
        // fault 3 during SETTLE
        arm_req = 1'b1; tick(); arm_req = 1'b0;
        repeat (5) tick();
        fail_rate = 1'b1;
        repeat (3) tick();
        m_count++;
        checks++; if (ctrl_state !== ST_FAULT || laser_ready !== 1'b0) begin errors++; $display("FAIL la_settle_fault got state %0d ready %0b want %0d 0", ctrl_state, laser_ready, ST_FAULT); end
        checks++; if (fault_count !== 8'(m_count) || fault_code !== 3'b100) begin errors++; $display("FAIL la_settle_count got %0d code %0b want %0d 100", fault_count, fault_code, m_count); end
        fail_rate = 1'b0;
        repeat (4) tick();
        recover(clr_n, lock_n, code);
        // fault 4 reaches the limit
        arm_wait(n);
        fail_upper = 1'b1; fail_lower = 1'b1;
        repeat (3) tick();
        m_count++;
        checks++; if (ctrl_state !== (m_count >= MAXF ? ST_LATCHED : ST_FAULT)) begin errors++; $display("FAIL la_latched got %0d want %0d", ctrl_state, ST_LATCHED); end
        checks++; if (fault_count !== 8'(m_count) || fault_code !== 3'b011) begin errors++; $display("FAIL la_latched_count got %0d code %0b want %0d 011", fault_count, fault_code, m_count); end
        fail_upper = 1'b0; fail_lower = 1'b0;
        ack_fault = 1'b1; tick(); ack_fault = 1'b0;
        arm_req = 1'b1; tick(); arm_req = 1'b0;
        repeat (40) tick();
        checks++; if (ctrl_state !== ST_LATCHED || laser_ready !== 1'b0 || clear_fail !== 1'b0) begin errors++; $display("FAIL la_stuck got state %0d ready %0b clear %0b want %0d 0 0", ctrl_state, laser_ready, clear_fail, ST_LATCHED); end
        do_reset();
        checks++; if (ctrl_state !== ST_IDLE || fault_count !== 8'd0 || fault_code !== 3'b000) begin errors++; $display("FAIL la_reset got state %0d count %0d code %0b want %0d 0 000", ctrl_state, fault_count, fault_code, ST_IDLE); end
    endtask

    task automatic test_rst_during_clear();
        int n;
        do_reset();
        write_cfg(CFG_PW_LOWER, 100);
        write_cfg(CFG_PW_UPPER, 200);
        write_cfg(CFG_RATE_LOWER, 1000);
        arm_wait(n);
        fail_lower = 1'b1;
        repeat (3) tick();
        fail_lower = 1'b0;
        repeat (3) tick();
        ack_fault = 1'b1; tick(); ack_fault = 1'b0;
        repeat (5) tick();
        checks++; if (clear_fail !== 1'b1 || pw_upper_lim !== 200) begin errors++; $display("FAIL rc_precond got clear %0b upper %0d want 1 200", clear_fail, pw_upper_lim); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (clear_fail !== 1'b0 || laser_ready !== 1'b0) begin errors++; $display("FAIL rc_async_outputs got clear %0b ready %0b want 0 0", clear_fail, laser_ready); end
        checks++; if ({pw_lower_lim, pw_upper_lim, rate_lower_lim} !== '0) begin errors++; $display("FAIL rc_async_limits got %0d/%0d/%0d want 0", pw_lower_lim, pw_upper_lim, rate_lower_lim); end
        checks++; if (ctrl_state !== ST_IDLE || fault_count !== 8'd0) begin errors++; $display("FAIL rc_async_state got %0d count %0d want %0d 0", ctrl_state, fault_count, ST_IDLE); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        arm_req = 1'b0; disarm_req = 1'b0; ack_fault = 1'b0;
        fail_lower = 1'b0; fail_upper = 1'b0; fail_rate = 1'b0;
        do_reset();
        test_reset();
        test_arm_timing();
        test_invalid();
        test_fault_upper();
        test_fault_disarm_same();
        test_fault_random();
        test_latched();
        test_rst_during_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
